pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined successor to the combinational shifter used in the DSP datapath.
//  - Four modes: logical left, logical right, arithmetic right, rotate right.
//  - Produces a sticky bit for FP alignment/normalisation; handles shift amounts >= WIDTH.
//  - Streams one operation per cycle under valid/ready flow control.
//  - Sits between the operand mux and the adder/normaliser of the FP/fixed-point units.

---
 rtl/shifter_pkg.sv | 29 ++
 rtl/shift_level.sv | 73 +++++++
 rtl/pipelined_barrel_shifter.sv | 121 ++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared shift-mode encodings and helpers that map log-shifter levels onto pipeline stages.
package shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  function automatic int levels_per_stage(input int shift_bits, input int stages);
    return (shift_bits + stages - 1) / stages;
  endfunction

  function automatic int stage_first_level(input int s, input int shift_bits, input int stages);
    int f;
    f = s * levels_per_stage(shift_bits, stages);
    return (f > shift_bits) ? shift_bits : f;
  endfunction

  // Last stage absorbs the remainder; a stage may end up with no levels and just register.
  function automatic int stage_level_count(input int s, input int shift_bits, input int stages);
    int f;
    int n;
    f = stage_first_level(s, shift_bits, stages);
    n = (s == stages - 1) ? (shift_bits - f) : levels_per_stage(shift_bits, stages);
    if (n > shift_bits - f) n = shift_bits - f;
    return n;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One conditional 2^K shift level for LSL/LSR/ASR/ROR plus the sticky bits it discards.
// Combinational, zero latency, no flow control.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] dat,
  input  logic [1:0]       mode,
  input  logic             sign,
  input  logic             en,
  output logic [WIDTH-1:0] dat_out,
  output logic             sticky
);

  localparam int S = (K >= 30) ? (1 << 30) : (1 << K);
  localparam int R = S % WIDTH;

  logic [WIDTH-1:0] lsl;
  logic [WIDTH-1:0] lsr;
  logic [WIDTH-1:0] asr;
  logic [WIDTH-1:0] ror;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] hi_mask;

  // Per-bit wiring; shifts of S >= WIDTH fall out naturally as full fill.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= S) begin : g_lsl_keep
      assign lsl[i]     = dat[i-S];
      assign lo_mask[i] = 1'b0;
    end else begin : g_lsl_fill
      assign lsl[i]     = 1'b0;
      assign lo_mask[i] = 1'b1;
    end
    if (i + S < WIDTH) begin : g_rsh_keep
      assign lsr[i]     = dat[i+S];
      assign asr[i]     = dat[i+S];
      assign hi_mask[i] = 1'b0;
    end else begin : g_rsh_fill
      assign lsr[i]     = 1'b0;
      assign asr[i]     = sign;
      assign hi_mask[i] = 1'b1;
    end
    assign ror[i] = dat[(i + R) % WIDTH];
  end

  always_comb begin
    dat_out = dat;
    sticky  = 1'b0;
    if (en) begin
      case (mode)
        MODE_LSL: begin
          dat_out = lsl;
          sticky  = |(dat & hi_mask);
        end
        MODE_LSR: begin
          dat_out = lsr;
          sticky  = |(dat & lo_mask);
        end
        MODE_ASR: begin
          dat_out = asr;
          sticky  = |(dat & lo_mask);
        end
        default: begin
          dat_out = ror;
          sticky  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log barrel shifter (LSL/LSR/ASR/ROR) with sticky output; latency STAGES cycles.
// Global stall: every stage holds while out_valid && !out_ready, in_ready = !out_valid || out_ready.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_BITS = 5,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [SHIFT_BITS-1:0] shift_amount,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  sticky
);

  logic                                  advance;
  logic [SHIFT_BITS-1:0]                 amt_in;
  logic [STAGES-1:0]                     vld_q, nxt_vld;
  logic [STAGES-1:0]                     stk_q, nxt_stk;
  logic [STAGES-1:0]                     sgn_q, nxt_sgn;
  logic [STAGES-1:0][WIDTH-1:0]          dat_q, nxt_dat;
  logic [STAGES-1:0][1:0]                mode_q, nxt_mode;
  logic [STAGES-1:0][SHIFT_BITS-1:0]     amt_q, nxt_amt;
  logic                                  unused_side;

  assign out_valid = vld_q[STAGES-1];
  assign data_out  = dat_q[STAGES-1];
  assign sticky    = stk_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Rotates wrap modulo WIDTH up front so non-power-of-two widths still rotate correctly.
  always_comb begin
    amt_in = shift_amount;
    if (mode == MODE_ROR) amt_in = SHIFT_BITS'(32'(shift_amount) % 32'(WIDTH));
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = stage_first_level(s, SHIFT_BITS, STAGES);
    localparam int CNT   = stage_level_count(s, SHIFT_BITS, STAGES);

    logic                  s_vld;
    logic [WIDTH-1:0]      s_dat;
    logic [1:0]            s_mode;
    logic                  s_sign;
    logic                  s_stk;
    logic [SHIFT_BITS-1:0] s_amt;
    logic [CNT:0][WIDTH-1:0] chain;
    logic [CNT:0]            lvl_stk;

    if (s == 0) begin : g_head
      assign s_vld  = in_valid;
      assign s_dat  = data_in;
      assign s_mode = mode;
      assign s_sign = data_in[WIDTH-1];
      assign s_stk  = 1'b0;
      assign s_amt  = amt_in;
    end else begin : g_body
      assign s_vld  = vld_q[s-1];
      assign s_dat  = dat_q[s-1];
      assign s_mode = mode_q[s-1];
      assign s_sign = sgn_q[s-1];
      assign s_stk  = stk_q[s-1];
      assign s_amt  = amt_q[s-1];
    end

    assign chain[0]     = s_dat;
    assign lvl_stk[CNT] = 1'b0;

    for (genvar j = 0; j < CNT; j++) begin : g_lvl
      shift_level #(
        .WIDTH (WIDTH),
        .K     (FIRST + j)
      ) u_lvl (
        .dat     (chain[j]),
        .mode    (s_mode),
        .sign    (s_sign),
        .en      (s_amt[FIRST+j]),
        .dat_out (chain[j+1]),
        .sticky  (lvl_stk[j])
      );
    end

    assign nxt_vld[s]  = s_vld;
    assign nxt_dat[s]  = chain[CNT];
    assign nxt_stk[s]  = s_stk | (|lvl_stk);
    assign nxt_mode[s] = s_mode;
    assign nxt_sgn[s]  = s_sign;
    assign nxt_amt[s]  = s_amt;
  end

  // Bubbles advance too, so a consumed output is refilled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      dat_q  <= '0;
      stk_q  <= '0;
      mode_q <= '0;
      sgn_q  <= '0;
      amt_q  <= '0;
    end else if (advance) begin
      vld_q  <= nxt_vld;
      dat_q  <= nxt_dat;
      stk_q  <= nxt_stk;
      mode_q <= nxt_mode;
      sgn_q  <= nxt_sgn;
      amt_q  <= nxt_amt;
    end
  end

  // Sideband of the final stage and already-consumed amount bits have no reader.
  assign unused_side = ^{amt_q, mode_q[STAGES-1], sgn_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised and directed bench for pipelined_barrel_shifter against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

  localparam int W  = 16;
  localparam int SB = 5;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic [SB-1:0] shift_amount;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          sticky;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } res_t;

  res_t exp_q[$];

  logic        hold_vld = 1'b0;
  logic [15:0] hold_dat;
  logic        hold_stk;
  logic        done_flag;

  pipelined_barrel_shifter #(
    .WIDTH      (W),
    .SHIFT_BITS (SB),
    .STAGES     (ST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .sticky       (sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on 32-bit integers.
  function automatic res_t ref_model(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m);
    res_t        o;
    int unsigned ae;
    int unsigned ud;
    int          sd;
    int unsigned r;
    ae  = (a > 5'd16) ? 16 : int'(a);
    ud  = int'(d);
    sd  = int'($signed(d));
    r   = int'(a) % 16;
    o.d = d;
    o.s = 1'b0;
    case (m)
      2'd0: begin
        o.d = (a >= 5'd16) ? 16'h0 : 16'(ud << a);
        o.s = (ae == 0) ? 1'b0 : ((ud >> (16 - ae)) != 0);
      end
      2'd1: begin
        o.d = (a >= 5'd16) ? 16'h0 : 16'(ud >> a);
        o.s = ((ud & ((32'd1 << ae) - 1)) != 0);
      end
      2'd2: begin
        o.d = 16'(sd >>> ae);
        o.s = ((ud & ((32'd1 << ae) - 1)) != 0);
      end
      default: begin
        o.d = 16'((ud >> r) | (ud << (16 - r)));
        o.s = 1'b0;
      end
    endcase
    return o;
  endfunction

  // Scoreboard, handshake-rule and hold-stability monitor.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      res_t e;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold_vld && out_valid) begin
        check("hold_dat", data_out, hold_dat);
        check("hold_stk", sticky, hold_stk);
      end
      hold_vld = out_valid && !out_ready;
      hold_dat = data_out;
      hold_stk = sticky;
      if (out_valid && out_ready) begin
        out_cnt++;
        check("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_dat", data_out, e.d);
          check("sb_stk", sticky, e.s);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(data_in, shift_amount, mode));
    end
  end

  task automatic send(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m);
    logic acc;
    int   n;
    n            = 0;
    acc          = 1'b0;
    in_valid     = 1'b1;
    data_in      = d;
    shift_amount = a;
    mode         = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    check("accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_one(input string tag, input logic [15:0] d, input logic [4:0] a,
                         input logic [1:0] m, input logic [15:0] ed, input logic es);
    int n;
    send(d, a, m);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_dat"}, data_out, ed);
    check({tag, "_stk"}, sticky, es);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int nops, input int idle_pct, input int ready_pct);
    done_flag = 1'b0;
    fork
      begin
        for (int i = 0; i < nops; i++) begin
          if (int'($urandom_range(0, 99)) < idle_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        in_valid  = 1'b0;
        done_flag = 1'b1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          out_ready = (int'($urandom_range(0, 99)) < ready_pct);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    res_t e1;
    rst          = 1'b1;
    in_valid     = 1'b0;
    data_in      = '0;
    shift_amount = '0;
    mode         = 2'd0;
    out_ready    = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 16'h0);
    check("rst_sticky", sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: presented this cycle, visible after the second edge.
    send(16'h00F1, 5'd4, 2'd0);
    in_valid = 1'b0;
    check("t1_lat_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t1_lat_vld", out_valid, 1'b1);
    check("t1_dat", data_out, 16'h0F10);
    check("t1_stk", sticky, 1'b0);
    @(posedge clk);
    #1;

    run_one("t2_asr", 16'h8001, 5'd3, 2'd2, 16'hF000, 1'b1);
    run_one("t2_lsr", 16'h8001, 5'd3, 2'd1, 16'h1000, 1'b1);
    run_one("t3_lsr20", 16'hFFFF, 5'd20, 2'd1, 16'h0000, 1'b1);
    run_one("t3_asr20", 16'h8000, 5'd20, 2'd2, 16'hFFFF, 1'b1);
    run_one("t3_ror17", 16'h0001, 5'd17, 2'd3, 16'h8000, 1'b0);
    run_one("a0_lsl", 16'hA5C3, 5'd0, 2'd0, 16'hA5C3, 1'b0);
    run_one("a0_asr", 16'h8421, 5'd0, 2'd2, 16'h8421, 1'b0);
    run_one("lsl16", 16'h8000, 5'd16, 2'd0, 16'h0000, 1'b1);
    run_one("lsr15", 16'h8000, 5'd15, 2'd1, 16'h0001, 1'b0);

    // Back-to-back stream with random backpressure.
    base = out_cnt;
    stream(8, 0, 50);
    check("t4_count", out_cnt - base, 8);

    // Stall with three ops.
    base      = out_cnt;
    out_ready = 1'b0;
    e1        = ref_model(16'h8001, 5'd3, 2'd2);
    send(16'h8001, 5'd3, 2'd2);
    send(16'hFFFF, 5'd20, 2'd1);
    data_in      = 16'h0001;
    shift_amount = 5'd17;
    mode         = 2'd3;
    repeat (3) begin
      @(negedge clk);
      check("t5_in_ready", in_ready, 1'b0);
      check("t5_out_valid", out_valid, 1'b1);
      check("t5_hold_first", data_out, e1.d);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0001, 5'd17, 2'd3);
    in_valid = 1'b0;
    drain();
    check("t5_count", out_cnt - base, 3);

    // Asynchronous reset with two ops in flight.
    send(16'h00F1, 5'd4, 2'd0);
    send(16'h8001, 5'd3, 2'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_data_out", data_out, 16'h0);
    check("t6_sticky", sticky, 1'b0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = out_cnt;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("t6_no_stale", out_valid, 1'b0);
    end
    check("t6_count", out_cnt - base, 0);

    // Random soak with idle gaps and backpressure.
    base = out_cnt;
    stream(150, 25, 65);
    check("soak_count", out_cnt - base, 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
